// File: rtl/bidir_port_counter_pkg.sv
// Shared constants and types for the bidirectional port counter.
package bidir_port_counter_pkg;
    localparam int WIDTH_DEF = 5;
    typedef logic [WIDTH_DEF-1:0] count_t;
endpackage

// File: rtl/bidir_port_iobuf.sv
// WIDTH-bit tristate pad buffer: drives pad when oe=1, always returns pad value.
module bidir_port_iobuf #(
    parameter int WIDTH = 5
) (
    input  logic [WIDTH-1:0] data_out,
    input  logic             oe,
    output logic [WIDTH-1:0] data_in,
    inout  wire  [WIDTH-1:0] pad
);
    // Output enable follows oe combinationally, so there is no turnaround cycle.
    assign pad     = oe ? data_out : {WIDTH{1'bz}};
    assign data_in = pad;
endmodule

// File: rtl/bidir_port_counter.sv
// Loadable up-counter sharing one bidirectional bus: drives and counts when
// en=1, releases the bus and loads from it when en=0.
module bidir_port_counter
    import bidir_port_counter_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    inout  wire  [WIDTH-1:0] bidir
);
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic [WIDTH-1:0] bus_in;

    bidir_port_iobuf #(.WIDTH(WIDTH)) u_iobuf (
        .data_out (count_q),
        .oe       (en),
        .data_in  (bus_in),
        .pad      (bidir)
    );

    // Next count: load from the pins while released, otherwise increment (wraps).
    always_comb begin
        count_d = count_q;
        if (!en) count_d = bus_in;
        else     count_d = count_q + {{(WIDTH-1){1'b0}}, 1'b1};
    end

    // Count register; reset wins over both load and increment.
    always_ff @(posedge clk) begin
        if (rst) count_q <= '0;
        else     count_q <= count_d;
    end
endmodule

// File: tb/tb_bidir_port_counter.sv
// Randomized and directed bench for bidir_port_counter against an integer model.
module tb_bidir_port_counter;
    localparam int W   = 5;
    localparam int MOD = 1 << W;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         en  = 1'b0;
    logic         tb_drv = 1'b0;
    logic [W-1:0] tb_val = '0;
    wire  [W-1:0] bidir;

    int vectors = 0;
    int errors  = 0;
    int model   = 0;

    assign bidir = tb_drv ? tb_val : {W{1'bz}};

    bidir_port_counter #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .bidir (bidir)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (%b) expected %0d", tag, got, got, exp);
        end
    endtask

    // One clock: apply inputs at negedge, check the bus, then advance the model
    // at the rising edge. The bench drives the bus only while en=0.
    task automatic cycle(input string tag, input logic r, input logic e, input int v);
        logic [W-1:0] exp;
        @(negedge clk);
        rst    = r;
        en     = e;
        tb_drv = !e;
        tb_val = W'(v);
        #1;
        exp = e ? W'(model) : W'(v);
        chk(tag, bidir, exp);
        @(posedge clk);
        if (r)       model = 0;
        else if (!e) model = v % MOD;
        else         model = (model + 1) % MOD;
    endtask

    initial begin
        // Reset with the bus externally driven, then reset with en=1.
        cycle("rst_drv", 1'b1, 1'b0, 3);
        cycle("rst_en",  1'b1, 1'b1, 0);
        for (int i = 0; i < 4; i++) cycle("post_rst", 1'b0, 1'b1, 0);  // 0,1,2,3

        // Load 5 then count 5,6,7,8.
        cycle("load5", 1'b0, 1'b0, 5);
        for (int i = 0; i < 4; i++) cycle("cnt5", 1'b0, 1'b1, 0);

        // Reload mid-run with 6 and with 15.
        cycle("load6", 1'b0, 1'b0, 6);
        for (int i = 0; i < 3; i++) cycle("cnt6", 1'b0, 1'b1, 0);
        cycle("load15", 1'b0, 1'b0, 15);
        for (int i = 0; i < 3; i++) cycle("cnt15", 1'b0, 1'b1, 0);

        // Wrap: 30,31,0,1.
        cycle("load30", 1'b0, 1'b0, 30);
        for (int i = 0; i < 4; i++) cycle("wrap", 1'b0, 1'b1, 0);

        // Reset beats load of 9; bus then shows 0.
        cycle("rst_prio", 1'b1, 1'b0, 9);
        cycle("rst_prio_out", 1'b0, 1'b1, 0);
        cycle("rst_prio_inc", 1'b0, 1'b1, 0);

        // Random mix of reset, load and count.
        for (int i = 0; i < 400; i++) begin
            logic r, e;
            r = ($urandom_range(0, 15) == 0);
            e = ($urandom_range(0, 2) != 0);
            cycle("rand", r, e, int'($urandom_range(0, MOD - 1)));
        end

        // Bus free of X/Z while driven.
        @(negedge clk);
        rst = 1'b0; en = 1'b1; tb_drv = 1'b0;
        #1;
        vectors++;
        if ($isunknown(bidir)) begin
            errors++;
            $display("FAIL drive_known: got %b expected no X/Z", bidir);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/bidir_port_counter.md
Name: bidir_port_counter

Overview:
- Loadable up-counter whose only data path is one shared bidirectional bus.
- When `en`=1 the block drives its count onto the bus and increments every clock.
- When `en`=0 the block releases the bus (high-Z) and loads its counter from the value an external agent drives onto it.
- Used as a leaf I/O block wherever a counter must share pins with a host that can preset it.

Parameters:
- WIDTH, 5, bit width of the counter and of the bidirectional bus.

Ports:
- clk  input  1  rising-edge clock, the only clock.
- rst  input  1  synchronous, active-high reset.
- en  input  1  direction/mode select: 1 = block drives bus and counts; 0 = bus is an input and the block loads from it.
- bidir  inout  WIDTH  shared data bus: counter value out when en=1, load value in when en=0.

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high (rst), sampled only on rising clk.
- State: one WIDTH-bit register `count`. No other state.
- Reset value: count = 0.
- Bus drive is combinational from en:
  - bidir = count while en=1.
  - bidir = all-Z while en=0.
  - This holds during reset as well: with en=1 the bus shows 0 from the first edge after rst is sampled high.
- Priority at each rising clk edge:
  1. rst=1 → count <= 0, regardless of en.
  2. else en=0 → count <= bidir (value on the pins, sampled at the edge).
  3. else en=1 → count <= count + 1, modulo 2^WIDTH (31 → 0 for WIDTH=5, no carry out, no saturation).
- Latency:
  - A value loaded at edge N appears on the bus as soon as en goes high.
  - The first increment happens at the first edge where en=1.
  - Example: load 5, raise en → bus shows 5, then 6 after the next edge, then 7, and so on.
- en changing between edges: only the level at the edge matters for the register update. The bus drive follows en immediately, so there is no internal turnaround cycle.
- The external agent must not drive the bus while en=1. Contention is a system-level error; the block does not detect it.
- Loading X/Z: if the bus is undriven while en=0, count loads X in simulation. Synthesis needs no special handling.
- Reset mid-count: the next edge forces 0; counting resumes from 0 on the following edges if en=1.

Decomposition:
- Shared package: WIDTH default constant and a count typedef (logic [WIDTH-1:0]).
- One natural sub-module, bidir_port_iobuf: a WIDTH-bit tristate buffer.
  - Inputs: data_out, oe.
  - Output: data_in.
  - Inout: pad.
- The top level holds the count register and next-state logic.

Test Plan:
- Reset: rst=1, en=1 for one edge → bus reads 0. Release rst with en=1 → bus reads 1, 2, 3 on successive edges.
- Load then count: en=0, drive bus=5 across one edge, then release the bus and set en=1 → bus reads 5 immediately, then 6, 7, 8 on the next three edges.
- Reload mid-run: count running, en=0, drive 6 for one edge, then en=1 → bus reads 6, then 7 and up. Repeat the sequence with a driven value of 15 → bus reads 15, then 16 and up.
- Wrap-around: load 30, en=1 → bus reads 30, 31, 0, 1.
- Direction: with en=0 and the bench not driving, the bus reads all-Z. With en=1, the bus equals count with no Z/X bits.
- Reset priority: rst=1 with en=0 and the bench driving 9 → count becomes 0, not 9. After rst drops with en=1, the bus reads 0.
